clk_div_ctrl: RTL



---
 rtl/clk_div_ctrl_pkg.sv | 24 ++
 rtl/clk_div_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/clk_div_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_ctrl_pkg
//  Description : Shared types and helpers for the clock-divider sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_div_ctrl_pkg;

    // Sequencer states: park on refclk, load ratio, reselect, report done
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        BYP  = 3'd1,
        LOAD = 3'd2,
        SEL  = 3'd3,
        DONE = 3'd4
    } clk_div_ctrl_state_e;

    // Dwell counter width: must hold 4*MAX_DIV-1 without wrapping
    function automatic int dwell_cnt_width(input int max_div);
        return $clog2(4 * max_div) + 1;
    endfunction

endpackage : clk_div_ctrl_pkg
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_ctrl
//  Description : Glitch-safe reconfiguration sequencer for the clock divider.
//                Accepts a ratio/enable request, parks the divider output on
//                refclk, loads the new ratio, waits two divided periods, then
//                reselects the divided clock and pulses done.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int MAX_DIV        = 64,
    parameter int SETTLE_CYCLES  = 8,
    parameter int RESET_HALF_DIV = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [$clog2(MAX_DIV)-1:0] cfg_half_div_less_1,
    input  logic                       cfg_div_en,
    output logic [$clog2(MAX_DIV)-1:0] half_div_less_1,
    output logic                       divclk_sel,
    output logic                       busy,
    output logic                       done
);

    localparam int RW = $clog2(MAX_DIV);
    localparam int CW = dwell_cnt_width(MAX_DIV);

    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [RW-1:0] RESET_HALF  = RW'(RESET_HALF_DIV);

    clk_div_ctrl_state_e state;
    logic [CW-1:0]       dwell_cnt;
    logic [RW-1:0]       hold_half;
    logic                hold_en;

    logic [CW-1:0]       load_dwell;
    logic                dwell_end;
    logic                same_cfg;

    // LOAD dwell minus one is 4*(h+1)-1 = {h, 2'b11}; zero-extended so the
    // largest ratio still fits the counter.
    assign load_dwell = CW'({hold_half, 2'b11});
    assign dwell_end  = (dwell_cnt == '0);
    assign same_cfg   = ({cfg_half_div_less_1, cfg_div_en} == {half_div_less_1, divclk_sel});

    // Handshake status is a pure decode of the registered state
    assign cfg_ready = (state == IDLE);
    assign busy      = !cfg_ready;

    // Sequencer FSM with dwell counter and registered divider controls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            dwell_cnt       <= '0;
            hold_half       <= RESET_HALF;
            hold_en         <= 1'b0;
            half_div_less_1 <= RESET_HALF;
            divclk_sel      <= 1'b0;
            done            <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        hold_half <= cfg_half_div_less_1;
                        hold_en   <= cfg_div_en;
                        if (same_cfg) begin
                            // Nothing to change: report completion immediately
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= BYP;
                            divclk_sel <= 1'b0;
                            dwell_cnt  <= SETTLE_LOAD;
                        end
                    end
                end
                BYP: begin
                    if (dwell_end) begin
                        state           <= LOAD;
                        half_div_less_1 <= hold_half;
                        dwell_cnt       <= load_dwell;
                    end else begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end
                end
                LOAD: begin
                    if (dwell_end) begin
                        state      <= SEL;
                        divclk_sel <= hold_en;
                        dwell_cnt  <= SETTLE_LOAD;
                    end else begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end
                end
                SEL: begin
                    if (dwell_end) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : clk_div_ctrl
`default_nettype wire
